// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART control path: arbiter states, line timing
// defaults and a small modulo-increment helper for round-robin pointers.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    localparam int CLOCK_FREQ = 50000000;
    localparam int BAUD_RATE  = 9600;
    // Start + 8 data + stop bits.
    localparam int FRAME_CYCLES = 10 * (CLOCK_FREQ / BAUD_RATE);
    localparam int DEFAULT_TIMEOUT_CYCLES = 65536;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: the first set bit of valid, searching
// upward from rr_ptr and wrapping modulo NUM_REQ.
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               any
);

    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        grant    = '0;
        index    = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        // Walk from the farthest candidate back to rr_ptr so the nearest one wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand     = (32'(rr_ptr) + 32'(k)) % 32'(NUM_REQ);
            cand_idx = IDX_W'(cand);
            if (valid[cand_idx]) begin
                index = cand_idx;
                any   = 1'b1;
            end
        end
        if (any) begin
            grant[index] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte sources with round-robin
// arbitration, per-message locking and a watchdog on the transmitter/owner.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = 17
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_send,
    input  logic                        tx_done,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] EXPIRE_AT = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic               locked;
    logic               last_q;
    logic [CNT_W-1:0]   timer;
    logic [CNT_W-1:0]   timer_inc;
    logic               expire;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [IDX_W-1:0]   win_idx;
    logic [DATA_W-1:0]  win_data;
    logic               win_last;
    logic               accept;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .valid  (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (pick_grant),
        .index  (pick_idx),
        .any    (pick_any)
    );

    // Handshake: requester i hands over a byte on a cycle where req_valid[i] &&
    // req_ready[i]. Ready is combinational, at most one-hot, only asserted in
    // IDLE, and never depends on req_data/req_last.
    always_comb begin
        win_idx   = locked ? owner : pick_idx;
        accept    = 1'b0;
        req_ready = '0;
        if (!rst && state == IDLE) begin
            if (locked) begin
                accept           = req_valid[owner];
                req_ready[owner] = req_valid[owner];
            end else begin
                accept    = pick_any;
                req_ready = pick_grant;
            end
        end
    end

    always_comb begin
        win_data = '0;
        win_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_data = req_data[i*DATA_W +: DATA_W];
                win_last = req_last[i];
            end
        end
    end

    assign timer_inc = timer + 1'b1;
    assign expire    = (timer_inc == EXPIRE_AT);
    assign busy      = (state != IDLE) || locked;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            locked      <= 1'b0;
            last_q      <= 1'b0;
            timer       <= '0;
            tx_data     <= '0;
            tx_send     <= 1'b0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            tx_send     <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_data  <= win_data;
                        grant_id <= win_idx;
                        last_q   <= win_last;
                        owner    <= win_idx;
                        locked   <= 1'b1;
                        tx_send  <= 1'b1;
                        timer    <= '0;
                        state    <= SEND;
                    end else if (locked) begin
                        // Owner went quiet mid-message: give up the lock eventually.
                        if (expire) begin
                            timeout_err <= 1'b1;
                            locked      <= 1'b0;
                            rr_ptr      <= IDX_W'(wrap_inc(int'(owner), NUM_REQ));
                            timer       <= '0;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                end
                SEND: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (tx_done) begin
                        timer <= '0;
                        state <= IDLE;
                        if (last_q) begin
                            locked <= 1'b0;
                            rr_ptr <= IDX_W'(wrap_inc(int'(grant_id), NUM_REQ));
                        end
                    end else if (expire) begin
                        timeout_err <= 1'b1;
                        locked      <= 1'b0;
                        rr_ptr      <= IDX_W'(wrap_inc(int'(owner), NUM_REQ));
                        timer       <= '0;
                        state       <= IDLE;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-requester byte sources, a
// transmitter model and a message-level round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 100;
    localparam int CNT_W   = 17;
    localparam int DEPTH   = 128;
    localparam int OBS_MAX = 512;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_last = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_send;
    logic                      tx_done = 1'b0;
    logic [1:0]                grant_id;
    logic                      busy;
    logic                      timeout_err;

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_send     (tx_send),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Source byte stores (written by the main flow) and engine-side read pointers
    logic [7:0] src_data [NUM_REQ][DEPTH];
    logic       src_last [NUM_REQ][DEPTH];
    int         src_wr [NUM_REQ] = '{default: 0};
    int         src_rd [NUM_REQ] = '{default: 0};

    // Observation log (written by the engine)
    logic [7:0] obs_data [OBS_MAX];
    logic [1:0] obs_id   [OBS_MAX];
    int         obs_gap  [OBS_MAX];
    int         obs_cyc  [OBS_MAX];
    int         obs_n = 0;
    int         to_n = 0;
    int         to_cyc = 0;

    int         cyc = 0;
    int         done_cnt = 0;
    int         last_done_cyc = 0;
    int         inject_req = 0;
    int         inject_seen = 0;
    logic       stuck = 1'b0;
    logic [NUM_REQ-1:0] fire = '0;

    // Engine: drives requester inputs and the transmitter model on the falling
    // edge, logs DUT activity, and samples handshakes just before the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (fire[i]) src_rd[i]++;
            end
            tx_done = 1'b0;
            if (inject_seen != inject_req) begin
                inject_seen   = inject_req;
                tx_done       = 1'b1;
                last_done_cyc = cyc;
            end else if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    tx_done       = 1'b1;
                    last_done_cyc = cyc;
                end
            end
            if (tx_send === 1'b1 && obs_n < OBS_MAX) begin
                obs_data[obs_n] = tx_data;
                obs_id[obs_n]   = grant_id;
                obs_gap[obs_n]  = cyc - last_done_cyc;
                obs_cyc[obs_n]  = cyc;
                obs_n++;
                if (!stuck) done_cnt = $urandom_range(3, 12);
            end
            if (timeout_err === 1'b1) begin
                to_n++;
                to_cyc = cyc;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (src_rd[i] < src_wr[i]) begin
                    req_valid[i]                = 1'b1;
                    req_data[i*DATA_W +: DATA_W] = src_data[i][src_rd[i]];
                    req_last[i]                 = src_last[i][src_rd[i]];
                end else begin
                    req_valid[i]                = 1'b0;
                    req_data[i*DATA_W +: DATA_W] = 8'($urandom);
                    req_last[i]                 = 1'($urandom);
                end
            end
            #4;
            fire = req_valid & req_ready & {NUM_REQ{~rst}};
        end
    end

    // Scoreboard and reference model state
    int          checks = 0;
    int          failures = 0;
    logic [9:0]  exp_q[$];
    int          obs_chk = 0;
    int          m_ptr = 0;
    int          m_lock = -1;
    int          m_rd [NUM_REQ] = '{default: 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input int i, input logic [7:0] d, input logic l);
        src_data[i][src_wr[i]] = d;
        src_last[i][src_wr[i]] = l;
        src_wr[i]++;
    endtask

    // Message-level model: the lock owner finishes its message; otherwise the
    // first requester with pending bytes at or after the pointer sends a whole
    // message and the pointer moves just past it.
    task automatic model_run();
        int   found;
        logic l;
        forever begin
            found = -1;
            if (m_lock >= 0) begin
                if (m_rd[m_lock] < src_wr[m_lock]) found = m_lock;
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    int j;
                    j = (m_ptr + k) % NUM_REQ;
                    if (found < 0 && m_rd[j] < src_wr[j]) found = j;
                end
            end
            if (found < 0) break;
            l = 1'b0;
            while (!l && m_rd[found] < src_wr[found]) begin
                exp_q.push_back({2'(found), src_data[found][m_rd[found]]});
                l = src_last[found][m_rd[found]];
                m_rd[found]++;
            end
            if (l) begin
                m_lock = -1;
                m_ptr  = (found + 1) % NUM_REQ;
            end else begin
                m_lock = found;
                break;
            end
        end
    endtask

    task automatic drain(input string tag, input bit gap_chk);
        int         budget;
        logic [9:0] e;
        bit         first;
        budget = 3000;
        while (budget > 0 && !(obs_n >= obs_chk + exp_q.size() && busy === 1'b0)) begin
            tick(1);
            budget--;
        end
        check({tag, "_drain_in_time"}, 32'(budget > 0), 1);
        first = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_chk < obs_n) begin
                check({tag, "_data"}, obs_data[obs_chk], e[7:0]);
                check({tag, "_grant_id"}, obs_id[obs_chk], e[9:8]);
                if (gap_chk && !first) check({tag, "_done_to_send_gap"}, obs_gap[obs_chk], 2);
            end else begin
                check({tag, "_sent_count"}, obs_n, obs_chk + 1);
            end
            obs_chk++;
            first = 1'b0;
        end
        check({tag, "_no_extra_send"}, obs_n, obs_chk);
    endtask

    task automatic wait_timeout(input string tag);
        int budget;
        budget = 400;
        while (budget > 0 && timeout_err !== 1'b1) begin
            tick(1);
            budget--;
        end
        check({tag, "_timeout_seen"}, timeout_err, 1);
    endtask

    initial begin
        int base_obs;
        int base_to;
        bit seen;

        // Reset state, with requester 0 already presenting a byte
        tick(3);
        push_byte(0, 8'h41, 1'b0);
        push_byte(0, 8'h42, 1'b0);
        push_byte(0, 8'h43, 1'b1);
        tick(2);
        check("rst_req_ready", req_ready, 0);
        check("rst_tx_send", tx_send, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst = 1'b0;

        // Single requester, three-byte message
        model_run();
        drain("single_msg", 1'b1);

        // Round-robin order between requesters 0 and 2
        push_byte(2, 8'hA2, 1'b1);
        push_byte(0, 8'hA0, 1'b1);
        model_run();
        drain("rr_ptr1", 1'b1);
        push_byte(3, 8'hB3, 1'b1);
        model_run();
        drain("rr_wrap", 1'b1);
        push_byte(0, 8'hC0, 1'b1);
        push_byte(2, 8'hC2, 1'b1);
        model_run();
        drain("rr_ptr0", 1'b1);

        // Lock: requester 3 is starved while requester 1 holds a message open
        push_byte(1, 8'h10, 1'b0);
        model_run();
        tick(30);
        check("lock_busy_held", busy, 1);
        push_byte(3, 8'h33, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            if (req_ready[3] === 1'b1) seen = 1'b1;
        end
        check("lock_req3_starved", 32'(seen), 0);
        push_byte(1, 8'h11, 1'b1);
        model_run();
        drain("lock_msg", 1'b0);

        // Stuck transmitter: watchdog fires TIMEOUT cycles after tx_send
        stuck = 1'b1;
        base_obs = obs_chk;
        base_to  = to_n;
        push_byte(0, 8'h5A, 1'b1);
        push_byte(1, 8'h6B, 1'b1);
        model_run();
        wait_timeout("stuck");
        check("stuck_busy_low", busy, 0);
        stuck = 1'b0;
        tick(1);
        check("stuck_timeout_latency", to_cyc - obs_cyc[base_obs], TIMEOUT);
        check("stuck_timeout_count", to_n, base_to + 1);
        drain("stuck", 1'b0);

        // Lock owner goes idle mid-message
        base_to = to_n;
        push_byte(2, 8'h2C, 1'b0);
        model_run();
        wait_timeout("idle_owner");
        check("idle_owner_busy_low", busy, 0);
        tick(1);
        check("idle_owner_latency", to_cyc - last_done_cyc, TIMEOUT);
        check("idle_owner_timeout_count", to_n, base_to + 1);
        m_lock = -1;
        m_ptr  = (2 + 1) % NUM_REQ;
        drain("idle_owner", 1'b0);
        push_byte(2, 8'h2D, 1'b1);
        push_byte(0, 8'h0D, 1'b1);
        model_run();
        drain("after_release", 1'b1);

        // Reset while waiting for tx_done
        stuck = 1'b1;
        push_byte(1, 8'h77, 1'b1);
        model_run();
        for (int c = 0; c < 50 && obs_n <= obs_chk; c++) tick(1);
        tick(5);
        rst = 1'b1;
        tick(1);
        check("midrst_tx_data", tx_data, 0);
        check("midrst_tx_send", tx_send, 0);
        check("midrst_grant_id", grant_id, 0);
        check("midrst_busy", busy, 0);
        check("midrst_timeout_err", timeout_err, 0);
        check("midrst_req_ready", req_ready, 0);
        rst = 1'b0;
        stuck = 1'b0;
        inject_req++;
        m_ptr  = 0;
        m_lock = -1;
        drain("midrst_abandoned", 1'b0);
        push_byte(3, 8'hD3, 1'b1);
        push_byte(1, 8'hD1, 1'b1);
        model_run();
        drain("post_rst", 1'b1);

        // Randomized message batches
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                int nm;
                nm = $urandom_range(0, 2);
                for (int m = 0; m < nm; m++) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) push_byte(i, 8'($urandom), b == len - 1);
                end
            end
            model_run();
            drain("random", 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_time_limit: got simulation still running, expected completion");
        $fatal(1, "time limit");
    end

endmodule
